// File: rtl/pc_sequencer.sv
// Program-counter stage: owns the fetch PC, selects jump/branch/buffered/sequential
// next address, buffers redirects raised while fetch is blocked, traps misaligned targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_x4,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        hold,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        redirect,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, RUN, TRAP} state_t;

  state_t      state;
  logic        pend_vld;
  logic [31:0] pend_tgt;

  logic        adv;
  logic        req;
  logic        take;
  logic [31:0] req_tgt;
  logic [31:0] tgt;

  assign pc_plus4 = pc + 32'd4;

  // Target of a request raised this cycle; a jump outranks a branch.
  always_comb begin
    adv     = (state == RUN) & imem_ready & ~hold;
    req     = jump_en | branch_taken;
    req_tgt = jump_en ? jump_target : (pc_plus4 + branch_offset_x4);
    take    = req | pend_vld;
    tgt     = req ? req_tgt : pend_tgt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      fetch_valid  <= 1'b0;
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
      pend_vld     <= 1'b0;
      pend_tgt     <= '0;
    end else begin
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
      if (!adv) begin
        // Fetch blocked: remember the newest redirect for the next advance.
        if (req) begin
          pend_vld <= 1'b1;
          pend_tgt <= req_tgt;
        end
        if (state != RUN) begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
      end else begin
        pend_vld <= 1'b0;
        if (!take) begin
          pc <= pc_plus4;
        end else if (tgt[1:0] == 2'b00) begin
          pc       <= tgt;
          redirect <= 1'b1;
        end else begin
          pc           <= EXC_VECTOR;
          state        <= TRAP;
          fetch_valid  <= 1'b0;
          redirect     <= 1'b1;
          misalign_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model pushes the expected
// outputs of each cycle, which are popped and compared after the clock edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_offset_x4;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        hold;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        redirect;
  logic        misalign_err;

  pc_sequencer dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_offset_x4(branch_offset_x4),
    .jump_en(jump_en), .jump_target(jump_target),
    .hold(hold), .imem_ready(imem_ready),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .redirect(redirect), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fv;
    logic        rd;
    logic        me;
  } exp_t;

  exp_t exp_q[$];

  int tests  = 0;
  int errors = 0;

  // Reference model state: 0 = idle, 1 = run, 2 = trap.
  int          m_st;
  logic [31:0] m_pc;
  logic        m_fv;
  logic        m_pv;
  logic [31:0] m_pt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_pc = 32'h0;
    m_fv = 1'b0;
    m_pv = 1'b0;
    m_pt = 32'h0;
    exp_q.delete();
  endtask

  // Predict the outputs after the coming edge from the inputs currently driven.
  task automatic model_push();
    exp_t        e;
    logic        adv, rq, have;
    logic [31:0] rt, t;
    adv  = (m_st == 1) && imem_ready && !hold;
    rq   = jump_en || branch_taken;
    rt   = jump_en ? jump_target : (m_pc + 32'd4 + branch_offset_x4);
    e.rd = 1'b0;
    e.me = 1'b0;
    if (!adv) begin
      if (rq) begin
        m_pv = 1'b1;
        m_pt = rt;
      end
      if (m_st != 1) begin
        m_st = 1;
        m_fv = 1'b1;
      end
    end else begin
      have = rq || m_pv;
      t    = rq ? rt : m_pt;
      m_pv = 1'b0;
      if (!have) m_pc = m_pc + 32'd4;
      else if (t[1:0] == 2'b00) begin
        m_pc = t;
        e.rd = 1'b1;
      end else begin
        m_pc = 32'h0000_0080;
        m_st = 2;
        m_fv = 1'b0;
        e.rd = 1'b1;
        e.me = 1'b1;
      end
    end
    e.pc  = m_pc;
    e.pc4 = m_pc + 32'd4;
    e.fv  = m_fv;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc4);
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
      chk("redirect", {31'd0, redirect}, {31'd0, e.rd});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.me});
    end
    branch_taken = 1'b0;
    jump_en      = 1'b0;
  endtask

  task automatic do_jump(input logic [31:0] t);
    jump_en     = 1'b1;
    jump_target = t;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    branch_taken = 1'b0; branch_offset_x4 = '0;
    jump_en = 1'b0; jump_target = '0;
    hold = 1'b0; imem_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_pc", pc, 32'h0);
    chk("idle_fv", {31'd0, fetch_valid}, 32'd0);

    // Startup sequence 0, 0, 4, 8
    cycle(); chk("run0_pc", pc, 32'h0); chk("run0_fv", {31'd0, fetch_valid}, 32'd1);
    cycle(); chk("run1_pc", pc, 32'h4);
    cycle(); chk("run2_pc", pc, 32'h8);

    // Backward branch from 0x100
    do_jump(32'h100);
    chk("jmp_pc", pc, 32'h100);
    branch_taken = 1'b1; branch_offset_x4 = 32'hFFFF_FFF0;
    cycle();
    chk("br_pc", pc, 32'h0F4); chk("br_redirect", {31'd0, redirect}, 32'd1);
    cycle();
    chk("br_redirect_end", {31'd0, redirect}, 32'd0);

    // Requests while held: newest (branch) wins over earlier jump
    do_jump(32'h20);
    hold = 1'b1;
    jump_en = 1'b1; jump_target = 32'h400;
    cycle(); chk("hold_pc", pc, 32'h20);
    branch_taken = 1'b1; branch_offset_x4 = 32'h8;
    cycle(); chk("hold_pc2", pc, 32'h20);
    hold = 1'b0;
    cycle(); chk("pend_pc", pc, 32'h2C); chk("pend_redirect", {31'd0, redirect}, 32'd1);
    cycle(); chk("pend_seq", pc, 32'h30);

    // Misaligned jump traps to the exception vector
    do_jump(32'h402);
    chk("trap_pc", pc, 32'h80);
    chk("trap_me", {31'd0, misalign_err}, 32'd1);
    chk("trap_fv", {31'd0, fetch_valid}, 32'd0);
    cycle(); chk("trap_exit_pc", pc, 32'h80); chk("trap_exit_fv", {31'd0, fetch_valid}, 32'd1);
    cycle(); chk("trap_seq", pc, 32'h84);

    // Address wrap
    do_jump(32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus4, 32'h0);
    cycle(); chk("wrap_pc", pc, 32'h0); chk("wrap_me", {31'd0, misalign_err}, 32'd0);

    // Async reset during hold with a buffered jump
    hold = 1'b1;
    jump_en = 1'b1; jump_target = 32'h300;
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_fv", {31'd0, fetch_valid}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    hold = 1'b0;
    cycle(); cycle(); cycle();
    chk("post_rst_pc", pc, 32'h8);

    // Random traffic checked entirely against the model
    for (int i = 0; i < 400; i++) begin
      hold             = ($urandom_range(0, 3) == 0);
      imem_ready       = ($urandom_range(0, 4) != 0);
      jump_en          = ($urandom_range(0, 9) == 0);
      branch_taken     = ($urandom_range(0, 7) == 0);
      jump_target      = {$urandom_range(0, 16'hFFFF), 14'd0, 2'($urandom_range(0, 5) == 0)};
      branch_offset_x4 = $urandom_range(0, 1) ? 32'($urandom_range(0, 64)) << 2
                                              : -(32'($urandom_range(0, 64)) << 2);
      if ($urandom_range(0, 19) == 0) branch_offset_x4[1] = 1'b1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage that consumes the word-scaled branch offset produced by the times-4 stage. It also consumes the jump target and the hazard hold. It owns the 32-bit PC register, chooses the next fetch address, and handshakes with instruction memory. Non-sequential requests that arrive while fetch is blocked are buffered. Misaligned targets are trapped to an exception vector.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_0080, PC loaded when a misaligned target is trapped.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  reset. Asynchronous and active-high.
branch_taken  input  1  single-cycle request: take the branch this cycle.
branch_offset_x4  input  32  branch byte offset, already multiplied by 4, two's complement.
jump_en  input  1  single-cycle request: jump this cycle.
jump_target  input  32  absolute jump byte address.
hold  input  1  pipeline stall from hazard logic.
imem_ready  input  1  instruction memory accepts the current pc.
pc  output  32  current fetch address.
pc_plus4  output  32  pc + 4, combinational from pc, modulo 2^32.
fetch_valid  output  1  pc is a valid fetch request this cycle.
redirect  output  1  one-cycle pulse: pc was just loaded with a non-sequential value (flush younger stages).
misalign_err  output  1  one-cycle pulse: a misaligned target was trapped.

Behaviour:
- Reset (async, any state, mid-operation included):
  - pc = RESET_PC, state = IDLE.
  - fetch_valid = 0, redirect = 0, misalign_err = 0, pending buffer cleared.
- States:
  - IDLE: one cycle after reset release, then unconditionally RUN.
  - RUN: fetch_valid = 1.
  - TRAP: one cycle; fetch_valid = 0, then RUN.
- Advance condition: adv = (state == RUN) & imem_ready & ~hold.
- Next-PC priority:
  - jump_en > branch_taken > pending buffer > sequential (pc_plus4).
  - Branch target = pc_plus4 + branch_offset_x4, 32-bit modulo. Overflow is ignored.
  - Jump target = jump_target, taken as-is.
- Pending buffer:
  - One entry: valid bit + 32-bit target.
  - A jump or branch request in a cycle with adv = 0 (any state) loads the buffer with its computed target.
  - A newer request overwrites an older one; the jump target wins if both arrive in the same cycle.
  - Buffer is consumed on the next cycle with adv = 1 and no new request. A new request on that cycle wins and clears the buffer.
- On adv with a non-sequential target T:
  - If T[1:0] == 0: pc <= T, redirect = 1 for the next cycle.
  - Else: pc <= EXC_VECTOR, state <= TRAP, misalign_err = 1 and redirect = 1 for the next cycle, buffer cleared.
- On adv with no request and no pending: pc <= pc_plus4. Wrap: 0xFFFF_FFFC -> 0x0000_0000, no error.
- When adv = 0: pc holds its value, redirect = 0, misalign_err = 0.
- redirect and misalign_err are registered outputs, high for exactly one cycle per event.
- Latency: request in cycle N with adv = 1 -> new pc visible in cycle N+1.

Test Plan:
- Reset release, imem_ready = 1, hold = 0 -> pc = 0x0 in IDLE (fetch_valid = 0), then 0x0, 0x4, 0x8 with fetch_valid = 1.
- pc = 0x100, branch_taken with offset 0xFFFF_FFF0 -> next pc = 0x0F4, redirect pulses once.
- hold = 1 at pc = 0x20, jump_en with target 0x400, then branch_taken with offset 0x8 while held; release -> pc = 0x2C, then 0x30.
- jump_en with target 0x402 -> pc = 0x80, misalign_err = 1 and redirect = 1 for one cycle, fetch_valid = 0 for one cycle, then pc = 0x84.
- Force pc = 0xFFFF_FFFC (jump to it), run sequentially -> pc = 0x0, no error.
- Assert rst mid-hold with a pending jump -> pc = 0x0 immediately; after release the pending target is never applied.
